// File: rtl/grant_monitor_pkg.sv
// Shared constants, channel FSM state type and overlap helper for grant_monitor.
package grant_monitor_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    // Channel index of each controller grant line within gnt_n
    localparam int CH_PG86BF = 0;
    localparam int CH_PG87BF = 1;
    localparam int CH_PG88BF = 2;
    localparam int CH_PG89BF = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HELD    = 2'd1,
        TIMEOUT = 2'd2
    } ch_state_e;

    // True when two or more grants are asserted together
    function automatic logic multi_grant(input logic [NUM_CH-1:0] v);
        int n = 0;
        for (int i = 0; i < NUM_CH; i++) n += int'(v[i]);
        return n >= 2;
    endfunction

endpackage

// File: rtl/grant_monitor_if.sv
// Grant-observation bus: raw grants and controls in, status and counts out.
interface grant_monitor_if
    import grant_monitor_pkg::*;
#(
    parameter int CNT_W = 8
);
    logic [NUM_CH-1:0] gnt_n;
    logic              clr;
    logic [SEL_W-1:0]  rd_sel;
    logic [CNT_W-1:0]  rd_count;
    logic [NUM_CH-1:0] active;
    logic [NUM_CH-1:0] grant_pulse;
    logic [NUM_CH-1:0] timeout;
    logic              conflict;

    modport master (
        output gnt_n, clr, rd_sel,
        input  rd_count, active, grant_pulse, timeout, conflict
    );

    modport slave (
        input  gnt_n, clr, rd_sel,
        output rd_count, active, grant_pulse, timeout, conflict
    );
endinterface

// File: rtl/grant_channel.sv
// One grant channel: hold-length FSM with timeout flag and a saturating grant counter.
module grant_channel
    import grant_monitor_pkg::*;
#(
    parameter int CNT_W    = 8,
    parameter int MAX_HOLD = 16,
    parameter int HOLD_W   = 5
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             gnt,      // registered, active-high grant
    input  logic             pulse,    // first cycle of a grant
    input  logic             clr,
    output logic             timeout,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(MAX_HOLD);
    localparam logic [CNT_W-1:0]  CNT_MAX    = {CNT_W{1'b1}};

    ch_state_e         state;
    logic [HOLD_W-1:0] hold;

    // Hold-length FSM; a release from any state returns to IDLE with hold cleared
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state   <= IDLE;
            hold    <= '0;
            timeout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt) begin
                        state <= HELD;
                        hold  <= HOLD_W'(1);
                    end
                end
                HELD: begin
                    if (!gnt) begin
                        state <= IDLE;
                        hold  <= '0;
                    end else if (hold == HOLD_LIMIT) begin
                        state   <= TIMEOUT;
                        timeout <= 1'b1;
                    end else begin
                        hold <= hold + 1'b1;
                    end
                end
                TIMEOUT: begin
                    // hold stays frozen until the grant goes away
                    if (!gnt) begin
                        state   <= IDLE;
                        hold    <= '0;
                        timeout <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    hold    <= '0;
                    timeout <= 1'b0;
                end
            endcase
        end
    end

    // Grant counter; clear wins over increment but still records a coincident grant
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= CNT_W'(pulse);
        end else if (pulse && cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/grant_monitor.sv
// Observer for the controller's active-low grant lines: sampling, per-channel
// hold/count tracking, sticky overlap detection and a count readback mux.
module grant_monitor
    import grant_monitor_pkg::*;
#(
    parameter int CNT_W    = 8,
    parameter int MAX_HOLD = 16,
    parameter int HOLD_W   = 5
) (
    input  logic           clock,
    input  logic           reset_n,
    grant_monitor_if.slave bus
);

    logic [NUM_CH-1:0]            s_gnt;
    logic [NUM_CH-1:0]            prev;
    logic [NUM_CH-1:0]            pulse;
    logic [NUM_CH-1:0]            to;
    logic [NUM_CH-1:0][CNT_W-1:0] cnt;
    logic                         conflict_q;

    // Sample stage: invert and register the grants, keep last cycle for edge detect
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            s_gnt <= '0;
            prev  <= '0;
        end else begin
            s_gnt <= ~bus.gnt_n;
            prev  <= s_gnt;
        end
    end

    assign pulse = s_gnt & ~prev;

    // Sticky overlap flag; a present overlap beats a clear
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            conflict_q <= 1'b0;
        end else if (multi_grant(s_gnt)) begin
            conflict_q <= 1'b1;
        end else if (bus.clr) begin
            conflict_q <= 1'b0;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        grant_channel #(
            .CNT_W    (CNT_W),
            .MAX_HOLD (MAX_HOLD),
            .HOLD_W   (HOLD_W)
        ) u_ch (
            .clock   (clock),
            .reset_n (reset_n),
            .gnt     (s_gnt[i]),
            .pulse   (pulse[i]),
            .clr     (bus.clr),
            .timeout (to[i]),
            .cnt     (cnt[i])
        );
    end

    assign bus.active      = s_gnt;
    assign bus.grant_pulse = pulse;
    assign bus.timeout     = to;
    assign bus.conflict    = conflict_q;
    assign bus.rd_count    = cnt[bus.rd_sel];

endmodule

// File: tb/tb_grant_monitor.sv
// Self-checking bench for grant_monitor: directed table, corner sequences and a
// randomized run against a run-length reference model.
module tb_grant_monitor;
    import grant_monitor_pkg::*;

    localparam int CNT_W    = 8;
    localparam int MAX_HOLD = 16;
    localparam int HOLD_W   = 5;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;

    logic clock = 1'b0;
    logic reset_n;
    always #5 clock = ~clock;

    grant_monitor_if #(.CNT_W(CNT_W)) bus();

    grant_monitor #(
        .CNT_W    (CNT_W),
        .MAX_HOLD (MAX_HOLD),
        .HOLD_W   (HOLD_W)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: sampled grants, how many consecutive sampled cycles each
    // grant has been seen, grant counts and the overlap flag
    logic [3:0] m_sgnt = '0;
    logic [3:0] m_prev = '0;
    int         m_run [4];
    int         m_cnt [4];
    logic       m_conf = 1'b0;

    typedef struct {
        logic [3:0] gnt_n;
        logic       clr;
        logic [1:0] rd_sel;
        logic [3:0] active;
        logic [3:0] pulse;
        logic [3:0] timeout;
        logic       conflict;
        logic [7:0] rd_count;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h @%0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_update();
        logic [3:0] p;
        if (!reset_n) begin
            m_sgnt = '0;
            m_prev = '0;
            m_conf = 1'b0;
            for (int i = 0; i < 4; i++) begin
                m_run[i] = 0;
                m_cnt[i] = 0;
            end
        end else begin
            p = m_sgnt & ~m_prev;
            if ($countones(m_sgnt) >= 2) m_conf = 1'b1;
            else if (bus.clr)            m_conf = 1'b0;
            for (int i = 0; i < 4; i++) begin
                if (bus.clr)                        m_cnt[i] = p[i] ? 1 : 0;
                else if (p[i] && m_cnt[i] < CNT_MAX) m_cnt[i] = m_cnt[i] + 1;
                m_run[i] = m_sgnt[i] ? m_run[i] + 1 : 0;
            end
            m_prev = m_sgnt;
            m_sgnt = ~bus.gnt_n;
        end
    endtask

    task automatic compare_model();
        logic [3:0] exp_to;
        for (int i = 0; i < 4; i++) exp_to[i] = (m_run[i] >= MAX_HOLD + 1);
        chk("mdl_active",   32'(bus.active),      32'(m_sgnt));
        chk("mdl_pulse",    32'(bus.grant_pulse), 32'(m_sgnt & ~m_prev));
        chk("mdl_timeout",  32'(bus.timeout),     32'(exp_to));
        chk("mdl_conflict", 32'(bus.conflict),    32'(m_conf));
        chk("mdl_rd_count", 32'(bus.rd_count),    32'(m_cnt[bus.rd_sel]));
    endtask

    // One clock: DUT samples current inputs, model follows, outputs compared after the edge
    task automatic step();
        @(posedge clock);
        model_update();
        #1;
        compare_model();
    endtask

    initial begin
        logic [3:0] hold_n;
        int         t_act, t_to, slow;

        reset_n     = 1'b0;
        bus.gnt_n   = 4'hF;
        bus.clr     = 1'b0;
        bus.rd_sel  = 2'd0;
        for (int i = 0; i < 4; i++) begin
            m_run[i] = 0;
            m_cnt[i] = 0;
        end

        // Reset and idle
        step();
        step();
        reset_n = 1'b1;
        for (int k = 0; k < 10; k++) step();
        chk("idle_active",  32'(bus.active),      0);
        chk("idle_pulse",   32'(bus.grant_pulse), 0);
        chk("idle_timeout", 32'(bus.timeout),     0);
        chk("idle_conflict",32'(bus.conflict),    0);
        for (int s = 0; s < 4; s++) begin
            bus.rd_sel = 2'(s);
            #1;
            chk("idle_rd_count", 32'(bus.rd_count), 0);
        end

        // Two 3-cycle grants on channel 2 separated by 2 idle cycles
        tbl[0] = '{4'hB, 1'b0, 2'd2, 4'h4, 4'h4, 4'h0, 1'b0, 8'd0};
        tbl[1] = '{4'hB, 1'b0, 2'd2, 4'h4, 4'h0, 4'h0, 1'b0, 8'd1};
        tbl[2] = '{4'hB, 1'b0, 2'd2, 4'h4, 4'h0, 4'h0, 1'b0, 8'd1};
        tbl[3] = '{4'hF, 1'b0, 2'd2, 4'h0, 4'h0, 4'h0, 1'b0, 8'd1};
        tbl[4] = '{4'hF, 1'b0, 2'd2, 4'h0, 4'h0, 4'h0, 1'b0, 8'd1};
        tbl[5] = '{4'hB, 1'b0, 2'd2, 4'h4, 4'h4, 4'h0, 1'b0, 8'd1};
        tbl[6] = '{4'hB, 1'b0, 2'd2, 4'h4, 4'h0, 4'h0, 1'b0, 8'd2};
        tbl[7] = '{4'hB, 1'b0, 2'd2, 4'h4, 4'h0, 4'h0, 1'b0, 8'd2};
        tbl[8] = '{4'hF, 1'b0, 2'd2, 4'h0, 4'h0, 4'h0, 1'b0, 8'd2};
        tbl[9] = '{4'hF, 1'b0, 2'd2, 4'h0, 4'h0, 4'h0, 1'b0, 8'd2};
        for (int v = 0; v < 10; v++) begin
            bus.gnt_n  = tbl[v].gnt_n;
            bus.clr    = tbl[v].clr;
            bus.rd_sel = tbl[v].rd_sel;
            step();
            chk($sformatf("tbl%0d_active", v),   32'(bus.active),      32'(tbl[v].active));
            chk($sformatf("tbl%0d_pulse", v),    32'(bus.grant_pulse), 32'(tbl[v].pulse));
            chk($sformatf("tbl%0d_timeout", v),  32'(bus.timeout),     32'(tbl[v].timeout));
            chk($sformatf("tbl%0d_conflict", v), 32'(bus.conflict),    32'(tbl[v].conflict));
            chk($sformatf("tbl%0d_rd_count", v), 32'(bus.rd_count),    32'(tbl[v].rd_count));
        end

        // Long hold on channel 0 reaches timeout
        bus.gnt_n = 4'hE;
        t_act = -1;
        t_to  = -1;
        for (int k = 1; k <= 25; k++) begin
            step();
            if (t_act < 0 && bus.active[0])  t_act = k;
            if (t_to < 0 && bus.timeout[0])  t_to  = k;
        end
        chk("to_rise_dist", 32'(t_to - t_act), 17);
        bus.gnt_n = 4'hF;
        step();
        chk("to_active_drop", 32'(bus.active[0]),  0);
        chk("to_still_high",  32'(bus.timeout[0]), 1);
        step();
        chk("to_fall", 32'(bus.timeout[0]), 0);
        bus.rd_sel = 2'd0;
        #1;
        chk("to_count", 32'(bus.rd_count), 1);

        // 300 grants on channel 3 saturate the counter, then clear with a coincident grant
        bus.rd_sel = 2'd3;
        for (int k = 0; k < 300; k++) begin
            bus.gnt_n = 4'h7;
            step();
            bus.gnt_n = 4'hF;
            step();
        end
        chk("sat_count", 32'(bus.rd_count), 255);
        bus.gnt_n = 4'h7;
        step();
        chk("clr_pulse_seen", 32'(bus.grant_pulse[3]), 1);
        bus.clr = 1'b1;
        step();
        bus.clr = 1'b0;
        chk("clr_with_pulse", 32'(bus.rd_count), 1);
        bus.gnt_n = 4'hF;
        step();

        // Overlap sets sticky conflict; clear only works without an overlap
        bus.gnt_n = 4'hA;
        step();
        bus.gnt_n = 4'hF;
        step();
        chk("conf_set", 32'(bus.conflict), 1);
        for (int k = 0; k < 5; k++) step();
        chk("conf_sticky", 32'(bus.conflict), 1);
        bus.gnt_n = 4'hA;
        step();
        bus.gnt_n = 4'hF;
        bus.clr   = 1'b1;
        step();
        chk("conf_clr_overlap", 32'(bus.conflict), 1);
        step();
        bus.clr = 1'b0;
        chk("conf_clr_clean", 32'(bus.conflict), 0);
        step();

        // Reset while channel 1 is granted: fresh pulse and count afterwards
        bus.rd_sel = 2'd1;
        bus.gnt_n  = 4'hD;
        for (int k = 0; k < 3; k++) step();
        reset_n = 1'b0;
        step();
        chk("rst_active", 32'(bus.active),      0);
        chk("rst_pulse",  32'(bus.grant_pulse), 0);
        chk("rst_count",  32'(bus.rd_count),    0);
        step();
        reset_n = 1'b1;
        step();
        chk("rst_new_pulse", 32'(bus.grant_pulse), 32'h2);
        step();
        chk("rst_new_count", 32'(bus.rd_count),    1);
        chk("rst_pulse_end", 32'(bus.grant_pulse), 0);
        bus.gnt_n = 4'hF;
        step();

        // Randomized run: per-channel grant toggling at two rates, random clears,
        // readback selection and occasional resets
        hold_n = 4'hF;
        for (int k = 0; k < 4000; k++) begin
            slow = (k / 500) % 2;
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(slow ? 39 : 3) == 0) hold_n[i] = ~hold_n[i];
            end
            bus.gnt_n  = hold_n;
            bus.clr    = ($urandom_range(15) == 0);
            bus.rd_sel = 2'($urandom_range(3));
            reset_n    = ($urandom_range(299) != 0);
            step();
        end
        reset_n = 1'b1;
        bus.clr = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/grant_monitor.md
# grant_monitor

Downstream observer for the four active-low channel-grant lines (`pg86bf`..`pg89bf`) of the priority/grant controller. It registers the grants, emits one-cycle grant pulses, and counts grants per channel in saturating counters. It measures how long each grant is held and raises a timeout when a grant exceeds a bound. It flags illegal overlap, i.e. more than one grant asserted in the same cycle, with a sticky bit. It feeds status and debug logic and has no effect on the controller itself.

## Interface
- `CNT_W`, 8: width of each per-channel grant counter.
- `MAX_HOLD`, 16: hold length in cycles at which a timeout asserts. Legal range 1..2^HOLD_W−1.
- `HOLD_W`, 5: width of the per-channel hold counter.
- `clock` in 1: the single clock. All state updates on its rising edge.
- `reset_n` in 1: reset, synchronous and active-low.
- `gnt_n` in 4: active-low grants. Bit 0 = `pg86bf`, bit 1 = `pg87bf`, bit 2 = `pg88bf`, bit 3 = `pg89bf`.
- `clr` in 1: synchronous clear of counters and the conflict flag.
- `rd_sel` in 2: selects the channel shown on `rd_count`.
- `rd_count` out CNT_W: grant count of channel `rd_sel`. Combinational mux of registered counters.
- `active` out 4: registered, active-high copy of the grants.
- `grant_pulse` out 4: high for exactly one cycle on each new grant.
- `timeout` out 4: channel is in TIMEOUT.
- `conflict` out 1: sticky overlap flag.

## Operation
- Sample stage:
  - `s_gnt <= ~gnt_n` every cycle.
  - `prev <= s_gnt`.
  - `active = s_gnt`.
  - `grant_pulse = s_gnt & ~prev`.
- Per-channel FSM, states IDLE, HELD, TIMEOUT:
  - IDLE→HELD when `s_gnt[i]` is 1; load `hold` with 1.
  - HELD:
    - `s_gnt[i]` is 0 → IDLE.
    - `hold == MAX_HOLD` → TIMEOUT.
    - Otherwise `hold` increments.
  - TIMEOUT: `hold` frozen; `s_gnt[i]` is 0 → IDLE.
  - A release always goes to IDLE and `hold` clears to 0.
- `timeout[i]` = (state == TIMEOUT). It is non-sticky and drops the cycle after the release is sampled.
- Grant counter `cnt[i]`:
  - Increments when `grant_pulse[i]` is 1.
  - Saturates at 2^CNT_W−1 and never wraps.
- `clr`:
  - Sets `cnt[*]` to 0 and `conflict` to 0.
  - When `clr` and `grant_pulse[i]` occur in the same cycle, `cnt[i]` becomes 1.
  - FSMs and `hold` are unaffected.
- `conflict`:
  - Set when `s_gnt` has two or more bits high.
  - Set takes priority over `clr` in the same cycle.
  - Stays set until a `clr` with no overlap present.

## Timing
- Reset (`reset_n` low at an edge) sets:
  - `s_gnt`, `prev` = 0.
  - All FSMs = IDLE, `hold` = 0, `cnt` = 0, `conflict` = 0.
  - Hence `active`, `grant_pulse`, `timeout` = 0 and `rd_count` = 0.
- Reset mid-grant: if the grant is still low after reset, it is seen as a new grant. A fresh pulse and count occur one cycle after reset deasserts.
- Latency from `gnt_n[i]` falling before edge t:
  - `active[i]` and `grant_pulse[i]` high after edge t.
  - FSM is in HELD after edge t+1.
- Timeout for a grant held continuously from edge t: `timeout[i]` is high after edge t+MAX_HOLD+1.
- A one-cycle glitch low on `gnt_n[i]` is a full grant: one pulse and one count, with HELD for one cycle.
- Re-grant immediately after a release (gap of one cycle high) produces a new pulse.
- `rd_count` reflects a counter update the cycle after the edge at which it occurs.

## Structure
- Package `grant_monitor_pkg`:
  - `NUM_CH` = 4.
  - `ch_state_e` enum {IDLE, HELD, TIMEOUT}.
  - Channel-index constants mapping to `pg86bf`..`pg89bf`.
- Sub-module `grant_channel`, instantiated NUM_CH times. It contains the FSM, the hold counter and the saturating grant counter.
- Top level contains:
  - the sample stage;
  - the overlap detector (popcount ≥ 2);
  - the `conflict` flag;
  - the `rd_sel` mux.

## Test plan
- Reset, then hold `gnt_n` = 4'b1111 for 10 cycles → all outputs 0, `rd_count` = 0 for every `rd_sel`.
- Drive `gnt_n[2]` low for 3 cycles, twice, with a gap of 2 high cycles → two single-cycle pulses on `grant_pulse[2]`; `rd_sel` = 2 gives `rd_count` = 2; `timeout` stays 0.
- With MAX_HOLD = 16, hold `gnt_n[0]` low for 25 cycles:
  - `timeout[0]` rises 17 cycles after `active[0]`;
  - it falls one cycle after `active[0]` drops;
  - count = 1.
- Make 300 grant pulses on channel 3 with CNT_W = 8 → `rd_count` stops at 255. Then `clr` coincident with a pulse → `rd_count` = 1.
- Drive `gnt_n` = 4'b1010 for 1 cycle → `conflict` = 1, and it survives 5 idle cycles. `clr` during an overlap keeps it at 1; `clr` with no overlap clears it to 0.
- Hold `gnt_n[1]` low, assert `reset_n` = 0 for 2 cycles, release reset → outputs 0 during reset, then a new pulse with count = 1.
